// File: rtl/led_matrix_scanner.sv
// Row-scan driver for a common-anode LED matrix: double-buffered frame load,
// per-row blanking gap, global PWM brightness and configurable pin polarity.
module led_matrix_scanner #(
    parameter int unsigned ROWS                = 5,
    parameter int unsigned COLS                = 5,
    parameter int unsigned DIV                 = 1000,
    parameter int unsigned BLANK               = 16,
    parameter int unsigned BW                  = 4,
    parameter bit          ANODE_ACTIVE_HIGH   = 1'b1,
    parameter bit          CATHODE_ACTIVE_HIGH = 1'b1
) (
    input  logic                 PIXEL_CLK,
    input  logic                 RESET_N,
    input  logic                 I_enable,
    input  logic [ROWS*COLS-1:0] I_frame,
    input  logic                 I_frame_valid,
    output logic                 O_frame_ready,
    input  logic [BW-1:0]        I_brightness,
    output logic [ROWS-1:0]      O_anode,
    output logic [COLS-1:0]      O_cathode,
    output logic                 O_frame_start
);

    localparam int unsigned CW     = $clog2(DIV);
    localparam int unsigned RW     = $clog2(ROWS);
    localparam int unsigned LEVELS = (1 << BW) - 1;
    localparam int unsigned STEP   = (DIV - BLANK) / LEVELS;
    // bright < 2^BW and STEP < 2^CW, so the lit-length product fits in PW bits
    localparam int unsigned PW     = BW + CW + 1;

    localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]   BLANK_C  = CW'(BLANK);
    localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
    localparam logic [ROWS-1:0] AN_OFF   = {ROWS{~ANODE_ACTIVE_HIGH}};
    localparam logic [COLS-1:0] CA_OFF   = {COLS{~CATHODE_ACTIVE_HIGH}};

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    logic [CW-1:0]        cnt;
    logic [RW-1:0]        row;
    logic [ROWS*COLS-1:0] act_frame;
    logic [BW-1:0]        act_bright;
    logic [ROWS*COLS-1:0] pend_frame;
    logic [BW-1:0]        pend_bright;
    logic                 pend_full;

    phase_t               phase;
    logic [PW-1:0]        drive_offset;
    logic [PW-1:0]        lit_len;
    logic                 window;
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      row_bits;
    logic                 boundary;
    logic                 promote;
    logic                 xfer;
    logic [ROWS-1:0]      anode_next;
    logic [COLS-1:0]      cathode_next;

    assign O_frame_ready = ~pend_full;

    assign boundary = I_enable && (cnt == CNT_LAST) && (row == ROW_LAST);
    assign promote  = pend_full && (boundary || !I_enable);
    assign xfer     = I_frame_valid && O_frame_ready;

    always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
            row <= '0;
        end else if (!I_enable) begin
            cnt <= '0;
            row <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Promotion reads the old pending content before a same-cycle transfer refills it
    always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            act_frame   <= '0;
            act_bright  <= '0;
            pend_frame  <= '0;
            pend_bright <= '0;
            pend_full   <= 1'b0;
        end else begin
            if (promote) begin
                act_frame  <= pend_frame;
                act_bright <= pend_bright;
            end
            if (xfer) begin
                pend_frame  <= I_frame;
                pend_bright <= I_brightness;
            end
            pend_full <= xfer || (pend_full && !promote);
        end
    end

    always_comb begin
        phase        = (cnt < BLANK_C) ? PH_BLANK : PH_DRIVE;
        drive_offset = PW'(cnt) - PW'(BLANK);
        lit_len      = PW'(act_bright) * PW'(STEP);
        window       = (act_bright == {BW{1'b1}}) || (drive_offset < lit_len);
    end

    always_comb begin
        row_sel  = '0;
        row_bits = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row == RW'(r)) begin
                row_sel[r] = 1'b1;
                row_bits   = act_frame[r*COLS +: COLS];
            end
        end
    end

    always_comb begin
        anode_next   = AN_OFF;
        cathode_next = CA_OFF;
        if (I_enable && (phase == PH_DRIVE) && window) begin
            anode_next   = ANODE_ACTIVE_HIGH   ? row_sel  : ~row_sel;
            cathode_next = CATHODE_ACTIVE_HIGH ? row_bits : ~row_bits;
        end
    end

    always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            O_anode       <= AN_OFF;
            O_cathode     <= CA_OFF;
            O_frame_start <= 1'b0;
        end else begin
            O_anode       <= anode_next;
            O_cathode     <= cathode_next;
            O_frame_start <= I_enable && (cnt == '0) && (row == '0);
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: frame-position model checked every cycle on an
// active-high and an active-low instance, plus hand-computed literal checks.
module tb_led_matrix_scanner;

    localparam int ROWS  = 5;
    localparam int COLS  = 5;
    localparam int DIV   = 20;
    localparam int BLANK = 4;
    localparam int BW    = 2;
    localparam int FRAME = ROWS * DIV;
    localparam int MAXB  = 3;
    localparam int STEP  = 5;

    localparam logic [24:0] F1 = {5'h10, 5'h08, 5'h04, 5'h02, 5'h01};

    logic        PIXEL_CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        I_enable = 1'b0;
    logic [24:0] I_frame = '0;
    logic        I_frame_valid = 1'b0;
    logic [1:0]  I_brightness = '0;

    logic        ready_h, fs_h, ready_l, fs_l;
    logic [4:0]  an_h, ca_h, an_l, ca_l;

    bit clk_run = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK), .BW(BW),
        .ANODE_ACTIVE_HIGH(1'b1), .CATHODE_ACTIVE_HIGH(1'b1)
    ) dut_h (
        .PIXEL_CLK(PIXEL_CLK), .RESET_N(RESET_N), .I_enable(I_enable),
        .I_frame(I_frame), .I_frame_valid(I_frame_valid), .O_frame_ready(ready_h),
        .I_brightness(I_brightness), .O_anode(an_h), .O_cathode(ca_h),
        .O_frame_start(fs_h)
    );

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK), .BW(BW),
        .ANODE_ACTIVE_HIGH(1'b0), .CATHODE_ACTIVE_HIGH(1'b0)
    ) dut_l (
        .PIXEL_CLK(PIXEL_CLK), .RESET_N(RESET_N), .I_enable(I_enable),
        .I_frame(I_frame), .I_frame_valid(I_frame_valid), .O_frame_ready(ready_l),
        .I_brightness(I_brightness), .O_anode(an_l), .O_cathode(ca_l),
        .O_frame_start(fs_l)
    );

    always begin
        #5;
        if (clk_run) PIXEL_CLK = ~PIXEL_CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame since enable, buffers as plain slots
    int          pos;
    logic [24:0] m_act, m_pend;
    int          m_abright, m_pbright;
    bit          m_pfull;
    logic [4:0]  e_an, e_ca;
    bit          e_fs, e_ready;

    always @(posedge PIXEL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pos = 0; m_act = '0; m_pend = '0; m_abright = 0; m_pbright = 0;
            m_pfull = 1'b0; e_an = '0; e_ca = '0; e_fs = 1'b0; e_ready = 1'b1;
        end else begin
            bit take, boundary;
            int r, c;
            e_an = '0; e_ca = '0; e_fs = 1'b0;
            if (I_enable) begin
                r = pos / DIV;
                c = pos % DIV;
                e_fs = (pos == 0);
                if (c >= BLANK && (m_abright == MAXB || (c - BLANK) < m_abright * STEP)) begin
                    e_an[r] = 1'b1;
                    e_ca = m_act[r*COLS +: 5];
                end
            end
            boundary = I_enable && (pos == FRAME - 1);
            take = I_frame_valid && !m_pfull;
            if (m_pfull && (boundary || !I_enable)) begin
                m_act = m_pend; m_abright = m_pbright; m_pfull = 1'b0;
            end
            if (take) begin
                m_pend = I_frame; m_pbright = int'(I_brightness); m_pfull = 1'b1;
            end
            pos = I_enable ? (pos + 1) % FRAME : 0;
            e_ready = !m_pfull;
        end
    end

    always @(negedge PIXEL_CLK) begin
        logic [4:0] inv_an, inv_ca;
        if (RESET_N) begin
            inv_an = ~e_an;
            inv_ca = ~e_ca;
            chk("anode_h", an_h, e_an);
            chk("cathode_h", ca_h, e_ca);
            chk("ready_h", ready_h, e_ready);
            chk("start_h", fs_h, e_fs);
            chk("anode_l", an_l, inv_an);
            chk("cathode_l", ca_l, inv_ca);
            chk("ready_l", ready_l, e_ready);
            chk("start_l", fs_l, e_fs);
        end
    end

    task automatic adv(input int to);
        while (cyc < to) begin
            @(negedge PIXEL_CLK);
            cyc++;
        end
    endtask

    task automatic start_scan();
        I_enable = 1'b1;
        cyc = 0;
    endtask

    task automatic load_idle(input logic [24:0] f, input logic [1:0] b);
        I_enable = 1'b0;
        I_frame = f;
        I_brightness = b;
        I_frame_valid = 1'b1;
        @(negedge PIXEL_CLK);
        I_frame_valid = 1'b0;
        @(negedge PIXEL_CLK);
        @(negedge PIXEL_CLK);
    endtask

    initial begin
        #1 RESET_N = 1'b0;
        #2;
        chk("rst_anode", an_h, 5'h00);
        chk("rst_cathode", ca_h, 5'h00);
        chk("rst_ready", ready_h, 1'b1);
        chk("rst_start", fs_h, 1'b0);
        chk("rst_anode_l", an_l, 5'h1F);
        chk("rst_cathode_l", ca_l, 5'h1F);
        clk_run = 1'b1;
        @(posedge PIXEL_CLK);
        #2 RESET_N = 1'b1;
        repeat (3) @(negedge PIXEL_CLK);
        chk("idle_anode", an_h, 5'h00);
        chk("idle_cathode", ca_h, 5'h00);

        // full brightness
        load_idle(F1, 2'd3);
        chk("load_ready", ready_h, 1'b1);
        start_scan();
        adv(1);   chk("fb_start1", fs_h, 1'b1);
        adv(4);   chk("fb_blank_an", an_h, 5'h00); chk("fb_blank_ca", ca_h, 5'h00);
        adv(5);   chk("fb_r0_an", an_h, 5'h01); chk("fb_r0_ca", ca_h, 5'h01);
        adv(20);  chk("fb_r0_end", an_h, 5'h01);
        adv(21);  chk("fb_r1_blank", an_h, 5'h00);
        adv(25);  chk("fb_r1_an", an_h, 5'h02); chk("fb_r1_ca", ca_h, 5'h02);
        adv(85);  chk("fb_r4_an", an_h, 5'h10); chk("fb_r4_ca", ca_h, 5'h10);
        adv(100); chk("fb_start100", fs_h, 1'b0);
        adv(101); chk("fb_start101", fs_h, 1'b1);

        // PWM brightness 1, then 0
        load_idle(F1, 2'd1);
        start_scan();
        adv(4);   chk("pwm_blank", an_h, 5'h00);
        adv(5);   chk("pwm_on_an", an_h, 5'h01); chk("pwm_on_ca", ca_h, 5'h01);
        adv(9);   chk("pwm_last_on", an_h, 5'h01);
        adv(10);  chk("pwm_off", an_h, 5'h00);
        adv(29);  chk("pwm_r1_last", an_h, 5'h02);
        adv(30);  chk("pwm_r1_off", an_h, 5'h00);
        adv(100);
        load_idle(F1, 2'd0);
        start_scan();
        adv(5);   chk("b0_anode", an_h, 5'h00); chk("b0_cathode", ca_h, 5'h00);
        adv(45);

        // handshake: A then B back-to-back while scanning
        I_frame = '1;
        I_brightness = 2'd3;
        I_frame_valid = 1'b1;
        @(negedge PIXEL_CLK);
        chk("A_taken_ready", ready_h, 1'b0);
        I_frame = '0;
        begin
            int n;
            n = 0;
            while (ready_h !== 1'b1 && n < 2 * FRAME) begin
                @(negedge PIXEL_CLK);
                n++;
            end
        end
        chk("B_wait_ready", ready_h, 1'b1);
        @(negedge PIXEL_CLK);
        chk("B_taken_ready", ready_h, 1'b0);
        chk("A_frame_start", fs_h, 1'b1);
        I_frame_valid = 1'b0;
        cyc = 1;
        adv(5);   chk("A_shown_ca", ca_h, 5'h1F); chk("A_shown_an", an_h, 5'h01);
        adv(101); chk("B_frame_start", fs_h, 1'b1);
        adv(105); chk("B_shown_ca", ca_h, 5'h00); chk("B_shown_an", an_h, 5'h01);

        // async reset at row 2, cnt 10
        adv(150); chk("pre_rst_anode", an_h, 5'h04);
        #2 RESET_N = 1'b0;
        #1;
        chk("mid_rst_anode", an_h, 5'h00);
        chk("mid_rst_cathode", ca_h, 5'h00);
        chk("mid_rst_ready", ready_h, 1'b1);
        chk("mid_rst_anode_l", an_l, 5'h1F);
        chk("mid_rst_cathode_l", ca_l, 5'h1F);
        @(posedge PIXEL_CLK);
        #2 RESET_N = 1'b1;
        @(negedge PIXEL_CLK);
        cyc = 0;
        adv(1);   chk("post_rst_start", fs_h, 1'b1);
        adv(5);   chk("post_rst_anode", an_h, 5'h00); chk("post_rst_cathode", ca_h, 5'h00);

        // inverted polarity and enable toggling
        load_idle(F1, 2'd3);
        start_scan();
        adv(5);   chk("pol_anode_l", an_l, 5'h1E); chk("pol_cathode_l", ca_l, 5'h1E);
        adv(10);
        I_enable = 1'b0;
        @(negedge PIXEL_CLK);
        chk("dis_anode_l", an_l, 5'h1F);
        chk("dis_cathode_l", ca_l, 5'h1F);
        chk("dis_anode_h", an_h, 5'h00);
        start_scan();
        adv(1);   chk("reen_start_l", fs_l, 1'b1); chk("reen_start_h", fs_h, 1'b1);
        adv(5);   chk("reen_anode_l", an_l, 5'h1E);

        @(negedge PIXEL_CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
